// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - UART byte framer: parses SYNC/ADDR/LEN/payload/CHK frames
// and replays the payload as a burst of register writes.
module rx_frame_ctrl #(
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int         MAX_LEN = 8,
   parameter int         TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       rx_rdy_clr,
   output logic       wr_en,
   input  logic       wr_ready,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);
   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic          rx_rdy_clr_q, rx_rdy_clr_d;
   logic          wr_en_q, wr_en_d;
   logic [7:0]    wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          frame_ok_q, frame_ok_d;
   logic          frame_err_q, frame_err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic [7:0]    base_q, base_d;
   logic [7:0]    chk_q, chk_d;
   logic [LW-1:0] len_q, len_d;
   logic [IW-1:0] idx_q, idx_d, idx_nx;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [7:0]    pay_q [MAX_LEN];
   logic [7:0]    pay_d [MAX_LEN];
   logic          accept, timed, last_idx;

   always_comb begin
      accept   = rx_rdy && !rx_rdy_clr_q && (state_q != S_DRAIN);
      timed    = (state_q == S_ADDR) || (state_q == S_LEN) ||
                 (state_q == S_PAYLOAD) || (state_q == S_CHK);
      idx_nx   = idx_q + 1'b1;
      last_idx = (LW'(idx_q) == (len_q - LW'(1)));

      state_d      = state_q;
      rx_rdy_clr_d = accept;
      wr_en_d      = wr_en_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_ok_d   = 1'b0;
      frame_err_d  = 1'b0;
      err_code_d   = err_code_q;
      base_d       = base_q;
      chk_d        = chk_q;
      len_d        = len_q;
      idx_d        = idx_q;
      cnt_d        = accept ? '0 : cnt_q;
      pay_d        = pay_q;

      case (state_q)
         S_IDLE: begin
            if (accept && (rx_data == SYNC)) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (accept) begin
               base_d  = rx_data;
               chk_d   = rx_data;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (accept) begin
               chk_d = chk_q ^ rx_data;
               idx_d = '0;
               if (rx_data > MAX_LEN_B) begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd1;
               end else begin
                  len_d   = LW'(rx_data);
                  state_d = (rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (accept) begin
               pay_d[idx_q] = rx_data;
               chk_d        = chk_q ^ rx_data;
               idx_d        = idx_nx;
               if (last_idx) state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (accept) begin
               idx_d = '0;
               if (rx_data != chk_q) begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd2;
               end else if (len_q == '0) begin
                  state_d    = S_IDLE;
                  frame_ok_d = 1'b1;
               end else begin
                  state_d   = S_DRAIN;
                  wr_en_d   = 1'b1;
                  wr_addr_d = base_q;
                  wr_data_d = pay_q[0];
               end
            end
         end
         S_DRAIN: begin
            // Next request is staged in the same edge the sink takes the current one.
            if (wr_ready) begin
               if (last_idx) begin
                  wr_en_d    = 1'b0;
                  frame_ok_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  idx_d     = idx_nx;
                  wr_addr_d = base_q + 8'(idx_nx);
                  wr_data_d = pay_q[idx_nx];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // An accepted byte always beats an expiring inter-byte timer.
      if (timed && !accept) begin
         if (cnt_q == TO_LAST) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rx_rdy_clr_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_ok_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= '0;
         base_q       <= '0;
         chk_q        <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         rx_rdy_clr_q <= rx_rdy_clr_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_ok_q   <= frame_ok_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
         base_q       <= base_d;
         chk_q        <= chk_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      pay_q <= pay_d;
   end

   assign rx_rdy_clr = rx_rdy_clr_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign frame_ok   = frame_ok_q;
   assign frame_err  = frame_err_q;
   assign err_code   = err_code_q;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - bench for rx_frame_ctrl: vector table, timeout/reset
// sequences, and random byte streams against a frame-level stream model.
module tb_rx_frame_ctrl;
   localparam logic [7:0] SYNC    = 8'hA5;
   localparam int         MAX_LEN = 8;
   localparam int         TIMEOUT = 20;

   typedef logic [19:0] ev_t;
   typedef logic [7:0]  bq_t[$];
   typedef ev_t         eq_t[$];

   typedef struct {
      string        name;
      int           nb;
      logic [95:0]  b;
      int           hold;
      int           ne;
      logic [199:0] ev;
      logic [1:0]   code;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic       rx_rdy_clr;
   logic       wr_en;
   logic       wr_ready;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   int  hold_req   = 0;
   bit  rand_ready = 1'b0;
   ev_t got[$];
   int  got_cyc[$];
   vec_t tbl [6];

   rx_frame_ctrl #(.SYNC(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .rx_rdy_clr(rx_rdy_clr), .wr_en(wr_en), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .frame_ok(frame_ok),
      .frame_err(frame_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   function automatic ev_t ev_w(input logic [7:0] a, input logic [7:0] d);
      return {4'd1, a, d};
   endfunction
   function automatic ev_t ev_err(input logic [1:0] c);
      return {4'd3, 14'd0, c};
   endfunction
   localparam ev_t EV_OK = {4'd2, 16'd0};

   // Frame-level view of a byte stream: what writes and pulses it must produce.
   function automatic eq_t model(input bq_t s);
      eq_t ev;
      int p;
      int n;
      logic [7:0] a, x;
      p = 0;
      while (p + 2 < s.size()) begin
         if (s[p] != SYNC) begin
            p++;
            continue;
         end
         a = s[p+1];
         n = int'(s[p+2]);
         if (n > MAX_LEN) begin
            ev.push_back(ev_err(2'd1));
            p += 3;
            continue;
         end
         if (p + 3 + n >= s.size()) break;
         x = a ^ s[p+2];
         for (int i = 0; i < n; i++) x ^= s[p+3+i];
         if (x != s[p+3+n]) ev.push_back(ev_err(2'd2));
         else begin
            for (int i = 0; i < n; i++) ev.push_back(ev_w(a + 8'(i), s[p+3+i]));
            ev.push_back(EV_OK);
         end
         p += 4 + n;
      end
      return ev;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Presents one byte until the DUT clears it; clr_at is the cycle rx_rdy_clr is high.
   task automatic send(input logic [7:0] b, output int clr_at);
      int n;
      rx_rdy  = 1'b1;
      rx_data = b;
      n = 0;
      do begin
         tick();
         n++;
      end while (!rx_rdy_clr && n < 200);
      rx_rdy = 1'b0;
      clr_at = cyc + 1;
      check($sformatf("accept_%02h", b), 32'(rx_rdy_clr), 32'd1);
   endtask

   initial begin
      int left;
      logic prev_en;
      left = 0;
      prev_en = 1'b0;
      wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (wr_en && !prev_en) left = hold_req;
         prev_en = wr_en;
         if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
         else if (wr_en && left > 0) begin
            wr_ready = 1'b0;
            left--;
         end else wr_ready = 1'b1;
      end
   end

   // Event recorder; code 4 = stalled request changed, code 5 = ok and err together.
   initial begin
      logic p_en, p_rdy;
      logic [7:0] p_a, p_d;
      p_en = 1'b0; p_rdy = 1'b0; p_a = '0; p_d = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n && p_en && !p_rdy && (!wr_en || wr_addr != p_a || wr_data != p_d)) begin
            got.push_back({4'd4, wr_addr, wr_data});
            got_cyc.push_back(cyc);
         end
         if (wr_en && wr_ready) begin
            got.push_back(ev_w(wr_addr, wr_data));
            got_cyc.push_back(cyc);
         end
         if (frame_ok && frame_err) begin
            got.push_back({4'd5, 16'd0});
            got_cyc.push_back(cyc);
         end else if (frame_ok) begin
            got.push_back(EV_OK);
            got_cyc.push_back(cyc);
         end else if (frame_err) begin
            got.push_back(ev_err(err_code));
            got_cyc.push_back(cyc);
         end
         p_en = wr_en; p_rdy = wr_ready; p_a = wr_addr; p_d = wr_data;
      end
   end

   initial begin
      int base;
      int lc;
      bq_t stream;
      eq_t exp_q;

      // CHK bytes follow the XOR rule over ADDR, LEN and payload.
      tbl[0] = '{"len2_ready", 6, 96'({8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21}), 0, 3,
                 200'({ev_w(8'h10, 8'h11), ev_w(8'h11, 8'h22), EV_OK}), 2'd0};
      tbl[1] = '{"addr_wrap_stall", 6, 96'({8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC}), 3, 3,
                 200'({ev_w(8'hFF, 8'hAA), ev_w(8'h00, 8'hBB), EV_OK}), 2'd0};
      tbl[2] = '{"bad_chk", 6, 96'({8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h00}), 0, 1,
                 200'(ev_err(2'd2)), 2'd2};
      tbl[3] = '{"bad_len9", 4, 96'({8'h00, 8'hA5, 8'h10, 8'h09}), 0, 1,
                 200'(ev_err(2'd1)), 2'd1};
      tbl[4] = '{"len0", 4, 96'({8'hA5, 8'h20, 8'h00, 8'h20}), 0, 1, 200'(EV_OK), 2'd1};
      tbl[5] = '{"len_max", 12, {8'hA5, 8'h30, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                                  8'h05, 8'h06, 8'h07, 8'h08, 8'h30}, 0, 9,
                 200'({ev_w(8'h30, 8'h01), ev_w(8'h31, 8'h02), ev_w(8'h32, 8'h03),
                       ev_w(8'h33, 8'h04), ev_w(8'h34, 8'h05), ev_w(8'h35, 8'h06),
                       ev_w(8'h36, 8'h07), ev_w(8'h37, 8'h08), EV_OK}), 2'd1};

      rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0;
      repeat (3) tick();
      check("rst_rx_rdy_clr", 32'(rx_rdy_clr), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_frame_ok", 32'(frame_ok), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int k = 0; k < 6; k++) begin
         base = got.size();
         hold_req = tbl[k].hold;
         lc = 0;
         for (int i = 0; i < tbl[k].nb; i++) send(tbl[k].b[8*(tbl[k].nb-1-i) +: 8], lc);
         repeat (30) tick();
         check({tbl[k].name, "_count"}, 32'(got.size() - base), 32'(tbl[k].ne));
         for (int i = 0; i < tbl[k].ne; i++) begin
            if (base + i < got.size()) begin
               check($sformatf("%s_ev%0d", tbl[k].name, i), 32'(got[base+i]),
                     32'(tbl[k].ev[20*(tbl[k].ne-1-i) +: 20]));
               if (i == 0)
                  check({tbl[k].name, "_first_cycle"}, 32'(got_cyc[base]), 32'(lc + tbl[k].hold));
               else
                  check($sformatf("%s_cycle%0d", tbl[k].name, i), 32'(got_cyc[base+i]),
                        32'(got_cyc[base+i-1] + 1));
            end
         end
         check({tbl[k].name, "_err_code"}, 32'(err_code), 32'(tbl[k].code));
      end

      // Inter-byte timeout after ADDR, then a LEN=0 frame.
      hold_req = 0;
      base = got.size();
      send(8'hA5, lc);
      send(8'h10, lc);
      repeat (TIMEOUT + 5) tick();
      check("timeout_count", 32'(got.size() - base), 32'd1);
      if (got.size() > base) begin
         check("timeout_ev", 32'(got[base]), 32'(ev_err(2'd3)));
         check("timeout_cycle", 32'(got_cyc[base]), 32'(lc + TIMEOUT));
      end
      check("timeout_err_code", 32'(err_code), 32'd3);

      // A byte landing on the last counted cycle wins over the timeout.
      base = got.size();
      send(8'hA5, lc);
      send(8'h10, lc);
      repeat (TIMEOUT - 1) tick();
      send(8'h00, lc);
      send(8'h10, lc);
      send(8'hA5, lc);
      send(8'h20, lc);
      send(8'h00, lc);
      send(8'h20, lc);
      repeat (10) tick();
      check("edge_count", 32'(got.size() - base), 32'd2);
      if (got.size() > base + 1) begin
         check("edge_ev0", 32'(got[base]), 32'(EV_OK));
         check("edge_ev1", 32'(got[base+1]), 32'(EV_OK));
      end
      check("edge_err_code", 32'(err_code), 32'd3);

      // Reset while a 4-byte frame is stalled in DRAIN.
      hold_req = 10;
      base = got.size();
      send(8'hA5, lc); send(8'h40, lc); send(8'h04, lc); send(8'h01, lc);
      send(8'h02, lc); send(8'h03, lc); send(8'h04, lc); send(8'h40, lc);
      repeat (2) tick();
      check("drain_wr_en", 32'(wr_en), 32'd1);
      rst_n = 1'b0;
      #1;
      check("drain_rst_wr_en", 32'(wr_en), 32'd0);
      check("drain_rst_wr_addr", 32'(wr_addr), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (15) tick();
      check("drain_rst_no_events", 32'(got.size() - base), 32'd0);
      check("drain_rst_err_code", 32'(err_code), 32'd0);
      hold_req = 0;
      base = got.size();
      send(8'hA5, lc); send(8'h50, lc); send(8'h01, lc); send(8'h77, lc); send(8'h26, lc);
      repeat (10) tick();
      check("post_rst_count", 32'(got.size() - base), 32'd2);
      if (got.size() > base + 1) begin
         check("post_rst_ev0", 32'(got[base]), 32'(ev_w(8'h50, 8'h77)));
         check("post_rst_ev1", 32'(got[base+1]), 32'(EV_OK));
      end

      // Random frames, junk, bad checksums and bad lengths with random back-pressure.
      for (int f = 0; f < 40; f++) begin
         int kind;
         logic [7:0] a, l, x, p;
         kind = $urandom_range(0, 3);
         a = 8'($urandom);
         case (kind)
            0: repeat ($urandom_range(1, 3)) begin
                  x = 8'($urandom);
                  if (x == SYNC) x = 8'h5A;
                  stream.push_back(x);
               end
            3: begin
                  stream.push_back(SYNC);
                  stream.push_back(a);
                  stream.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
               end
            default: begin
                  l = 8'($urandom_range(0, MAX_LEN));
                  stream.push_back(SYNC);
                  stream.push_back(a);
                  stream.push_back(l);
                  x = a ^ l;
                  for (int i = 0; i < int'(l); i++) begin
                     p = 8'($urandom);
                     stream.push_back(p);
                     x ^= p;
                  end
                  if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
                  stream.push_back(x);
               end
         endcase
      end
      rand_ready = 1'b1;
      base = got.size();
      foreach (stream[i]) begin
         send(stream[i], lc);
         repeat ($urandom_range(0, 3)) tick();
      end
      repeat (100) tick();
      exp_q = model(stream);
      check("rand_count", 32'(got.size() - base), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (base + i < got.size())
            check($sformatf("rand_ev%0d", i), 32'(got[base+i]), 32'(exp_q[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
